// File: rtl/clk_gen_downsampler_prog.sv
// Run-time programmable even-ratio clock downsampler.
// clk_o = clk_i / (2*(ds_o+1)), 50% duty. Ratio changes only at the end of
// a full output period (1->0 toggle), or immediately while parked.
// Includes a glitch-free enable, a rising-edge tick and a wrapping edge counter.
`timescale 1ns/1ps

module clk_gen_downsampler_prog #(
    parameter int WIDTH_P     = 8,
    parameter int DS_RESET_P  = 0,
    parameter int CNT_WIDTH_P = 16
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   en_i,
    input  logic                   ds_v_i,
    input  logic [WIDTH_P-1:0]     ds_i,
    output logic                   ds_ready_o,
    output logic                   clk_o,
    output logic                   tick_o,
    output logic [CNT_WIDTH_P-1:0] edge_cnt_o,
    output logic [WIDTH_P-1:0]     ds_o
);

    localparam logic [WIDTH_P-1:0] DS_RESET_L = WIDTH_P'(DS_RESET_P);

    // Registered state (outputs double as their own state registers).
    logic [WIDTH_P-1:0]     cnt_q;
    logic [WIDTH_P-1:0]     pend_q;
    logic                   pend_v_q;

    // Next-state values.
    logic [WIDTH_P-1:0]     cnt_d;
    logic [WIDTH_P-1:0]     pend_d;
    logic                   pend_v_d;
    logic [WIDTH_P-1:0]     ds_d;
    logic                   ready_d;
    logic                   clk_d;
    logic                   tick_d;
    logic [CNT_WIDTH_P-1:0] edge_d;

    // Decoded conditions for the current cycle.
    logic accept;     // config handshake completes this cycle
    logic parked;     // enable low and output already low: hold
    logic phase_end;  // current phase has lasted ds_o+1 cycles
    logic fall;       // clk_o toggles 1->0 this cycle (period boundary)
    logic rise;       // clk_o toggles 0->1 this cycle

    assign accept    = ds_v_i && ds_ready_o;
    assign parked    = !en_i && !clk_o;
    assign phase_end = !parked && (cnt_q == ds_o);
    assign fall      = phase_end && clk_o;
    assign rise      = phase_end && !clk_o;

    // Next-state logic: phase counting, toggling, apply and handshake.
    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path
        // leaves one unassigned and no latch is inferred.
        cnt_d    = cnt_q;
        clk_d    = clk_o;
        tick_d   = 1'b0;
        edge_d   = edge_cnt_o;
        ds_d     = ds_o;
        pend_d   = pend_q;
        pend_v_d = pend_v_q;
        ready_d  = ds_ready_o;

        // Phase counter: hold at zero while parked so a restart always
        // begins a full low phase, exactly as after reset.
        if (parked) begin
            cnt_d = '0;
        end else if (phase_end) begin
            cnt_d = '0;
            clk_d = !clk_o;
        end else begin
            cnt_d = cnt_q + WIDTH_P'(1);
        end

        if (rise) begin
            tick_d = 1'b1;
            edge_d = edge_cnt_o + CNT_WIDTH_P'(1);
        end

        // Apply only at a period boundary or while parked; cnt is zero in
        // both cases so the new ratio starts with a full low phase. A fall
        // with en_i low both applies and parks, since clk_d is 0 either way.
        if ((parked || fall) && pend_v_q) begin
            ds_d     = pend_q;
            pend_v_d = 1'b0;
            ready_d  = 1'b1;
        end

        // Accept can never coincide with an apply: ready is low whenever a
        // value is pending, so a source holding ds_v_i waits one more cycle.
        if (accept) begin
            pend_d   = ds_i;
            pend_v_d = 1'b1;
            ready_d  = 1'b0;
        end
    end

    // State register with synchronous active-high reset.
    always_ff @(posedge clk_i) begin
        // NOTE: non-blocking assignments so every flop samples the values
        // from before this edge, independent of statement order.
        if (reset_i) begin
            cnt_q      <= '0;
            clk_o      <= 1'b0;
            tick_o     <= 1'b0;
            edge_cnt_o <= '0;
            ds_o       <= DS_RESET_L;
            pend_q     <= DS_RESET_L;
            pend_v_q   <= 1'b0;
            ds_ready_o <= 1'b1;
        end else begin
            cnt_q      <= cnt_d;
            clk_o      <= clk_d;
            tick_o     <= tick_d;
            edge_cnt_o <= edge_d;
            ds_o       <= ds_d;
            pend_q     <= pend_d;
            pend_v_q   <= pend_v_d;
            ds_ready_o <= ready_d;
        end
    end

endmodule

// File: doc/clk_gen_downsampler_prog.md
Name: clk_gen_downsampler_prog

Overview:
Parametrised, run-time programmable clock downsampler for the clock-generator path. It divides the ring-oscillator output (clk_i) by an even ratio set through a valid/ready config port, and only switches ratio at full-period boundaries, so clk_o never glitches. It adds a glitch-free enable (parks low), a one-cycle rising-edge tick and a wrapping output-edge counter for on-chip frequency measurement. The output is registered; no combinational path from clk_i to clk_o.

Parameters:
WIDTH_P, 8, width of the downsample value; ratio = 2*(ds+1), max 2*2^WIDTH_P.
DS_RESET_P, 0, downsample value loaded at reset (must fit WIDTH_P).
CNT_WIDTH_P, 16, width of the output rising-edge counter.

Ports:
clk_i  in  1  oscillator clock; all logic on posedge.
reset_i  in  1  synchronous, active-high reset.
en_i  in  1  1 = run, 0 = finish the current high phase, then park clk_o low.
ds_v_i  in  1  config valid.
ds_i  in  WIDTH_P  new downsample value.
ds_ready_o  out  1  config ready (registered).
clk_o  out  1  divided clock (registered).
tick_o  out  1  one-cycle pulse, high in the same cycle clk_o first reads 1.
edge_cnt_o  out  CNT_WIDTH_P  count of clk_o rising edges, wraps.
ds_o  out  WIDTH_P  currently active downsample value.

Behaviour:
- One clock, synchronous active-high reset; every output is a flop.
- Reset values: clk_o=0, tick_o=0, edge_cnt_o=0, ds_o=DS_RESET_P, ds_ready_o=1, internal phase counter=0, pending buffer empty.
- Phase counter cnt (WIDTH_P bits) counts 0..ds_o while running.
  - When cnt==ds_o: cnt<=0 and clk_o toggles; otherwise cnt<=cnt+1.
  - Each phase lasts ds_o+1 cycles, so high = low = ds_o+1 cycles, duty 50%.
- Rising edge (clk_o 0->1 registered): tick_o<=1 for exactly that cycle; edge_cnt_o<=edge_cnt_o+1, wrapping all-ones->0.
- Config handshake:
  - Transfer when ds_v_i && ds_ready_o; ds_i is captured into a one-entry pending buffer.
  - ds_ready_o<=0 from the next cycle until the pending value is applied.
  - ds_v_i with ds_ready_o=0 is ignored; the source must hold it.
- Apply point: the pending value loads into ds_o on the cycle clk_o toggles 1->0 (end of a full period), with cnt<=0 in that cycle. The new ratio starts with the following low phase; ds_ready_o<=1 in the same update.
- Parked state (en_i=0 and clk_o=0): any pending value applies on the next cycle. Accept at cycle t -> ds_o updated and ds_ready_o=1 at t+2.
- Enable semantics:
  - en_i falling while clk_o=1: the high phase completes normally. On the 1->0 toggle, clk_o stays 0 and cnt<=0 (parked).
  - en_i falling while clk_o=0: park immediately; cnt<=0 and hold.
  - en_i rising from parked: cnt counts from 0; the first rising clk_o comes ds_o+1 cycles later. Same as after reset.
- Simultaneous events:
  - An apply and a new ds_v_i in the same cycle: the new value is not accepted that cycle, because ds_ready_o is still 0.
  - A fall toggle plus en_i=0 plus a pending value: apply and park together.
- Reset mid-operation: clk_o drops to 0 the cycle after reset_i samples high; the pending value is discarded and ds_o reverts to DS_RESET_P.
- Expected implementation size: about 150–250 lines of RTL.

Test Plan:
- Reset, DS_RESET_P=0, en_i=1 -> clk_o toggles every cycle (period 2); tick_o pulses every 2nd cycle; edge_cnt_o=5 after 10 cycles following reset release.
- Configure ds_i=3 while clk_o high in the period-2 state -> ds_o=3 after the next 1->0 toggle; then high/low 4 cycles each; ds_ready_o low for the interval between accept and apply.
- Hold ds_v_i=1 with a second value 7 while ds_ready_o=0 -> 7 accepted only after the first apply; no clk_o phase shorter than min(old,new)+1 cycles.
- Drop en_i mid high phase with ds_o=3 -> high phase still lasts 4 cycles, then clk_o stays 0 and tick_o stays 0. Raise en_i -> first rising edge exactly 4 cycles later.
- Parked, configure ds_i=255 (WIDTH_P=8) -> ds_o=255 at accept+2; after enable, period = 512 cycles.
- CNT_WIDTH_P=4, run 17 rising edges -> edge_cnt_o wraps to 1. Assert reset_i mid high phase -> next cycle clk_o=0, edge_cnt_o=0, ds_o=DS_RESET_P, ds_ready_o=1.
